// File: rtl/hall_axil_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between two requesters.
// One transaction in flight at a time; every response is returned to the requester that was granted.
module hall_axil_arbiter #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                ACLK,
    input  logic                ARESET,

    input  logic                req0_valid_i,
    input  logic                req0_we_i,
    input  logic [ADDR_W-1:0]   req0_addr_i,
    input  logic [DATA_W-1:0]   req0_wdata_i,
    output logic                req0_ack_o,
    output logic                req0_done_o,

    input  logic                req1_valid_i,
    input  logic                req1_we_i,
    input  logic [ADDR_W-1:0]   req1_addr_i,
    input  logic [DATA_W-1:0]   req1_wdata_i,
    output logic                req1_ack_o,
    output logic                req1_done_o,

    output logic [DATA_W-1:0]   rdata_o,
    output logic [1:0]          resp_o,
    output logic                busy_o,
    output logic                timeout_o,

    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [2:0]          M_AXI_ARPROT,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD,
        S_RD_DATA,
        S_DONE
    } state_t;

    state_t             state;
    logic               grant_q;
    logic               last_grant;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [CNT_W-1:0]   timer;

    logic               gnt1_c;
    logic               sel_we_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic [DATA_W-1:0]  sel_wdata_c;
    logic [CNT_W-1:0]   timer_inc_c;
    logic               aw_ok_c;
    logic               w_ok_c;
    logic               waiting_c;

    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    // Grant selection: a lone requester wins outright, a tie goes to the one not served last.
    always_comb begin
        gnt1_c      = req1_valid_i && (!req0_valid_i || !last_grant);
        sel_we_c    = gnt1_c ? req1_we_i    : req0_we_i;
        sel_addr_c  = (gnt1_c ? req1_addr_i : req0_addr_i) & ~ADDR_W'(3);
        sel_wdata_c = gnt1_c ? req1_wdata_i : req0_wdata_i;
        timer_inc_c = (timer == TO_MAX) ? timer : timer + CNT_W'(1);
        aw_ok_c     = !M_AXI_AWVALID || M_AXI_AWREADY;
        w_ok_c      = !M_AXI_WVALID  || M_AXI_WREADY;
        waiting_c   = (state == S_WR) || (state == S_WR_RESP) ||
                      (state == S_RD) || (state == S_RD_DATA);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= S_IDLE;
            grant_q       <= 1'b0;
            last_grant    <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            timer         <= '0;
            req0_ack_o    <= 1'b0;
            req1_ack_o    <= 1'b0;
            req0_done_o   <= 1'b0;
            req1_done_o   <= 1'b0;
            rdata_o       <= '0;
            resp_o        <= 2'b00;
            busy_o        <= 1'b0;
            timeout_o     <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            req0_ack_o  <= 1'b0;
            req1_ack_o  <= 1'b0;
            req0_done_o <= 1'b0;
            req1_done_o <= 1'b0;

            // Slave wait watchdog; transitions below restart it on every state entry.
            if (waiting_c) begin
                timer <= timer_inc_c;
                if (TIMEOUT != 0 && timer == TO_LAST) begin
                    timeout_o <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (req0_valid_i || req1_valid_i) begin
                        grant_q    <= gnt1_c;
                        last_grant <= gnt1_c;
                        req0_ack_o <= !gnt1_c;
                        req1_ack_o <= gnt1_c;
                        addr_q     <= sel_addr_c;
                        wdata_q    <= sel_wdata_c;
                        busy_o     <= 1'b1;
                        timer      <= '0;
                        if (sel_we_c) begin
                            state         <= S_WR;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end else begin
                            state         <= S_RD;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if (aw_ok_c && w_ok_c) begin
                        state        <= S_WR_RESP;
                        M_AXI_BREADY <= 1'b1;
                        timer        <= '0;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        state        <= S_DONE;
                        M_AXI_BREADY <= 1'b0;
                        resp_o       <= M_AXI_BRESP;
                        req0_done_o  <= !grant_q;
                        req1_done_o  <= grant_q;
                        timer        <= '0;
                    end
                end
                S_RD: begin
                    if (M_AXI_ARREADY) begin
                        state         <= S_RD_DATA;
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        timer         <= '0;
                    end
                end
                S_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        state        <= S_DONE;
                        M_AXI_RREADY <= 1'b0;
                        rdata_o      <= M_AXI_RDATA;
                        resp_o       <= M_AXI_RRESP;
                        req0_done_o  <= !grant_q;
                        req1_done_o  <= grant_q;
                        timer        <= '0;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
